// File: rtl/scan_pkg.sv
// Shared constants and state encoding for the selector scan sequencer.
// SCAN_PARITY_EN appends an even-parity bit to every frame.
package scan_pkg;

  localparam int unsigned DAT_W  = 8;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned CNT_W  = 4;

`ifdef SCAN_PARITY_EN
  localparam int unsigned LAST_CNT = 8;
`else
  localparam int unsigned LAST_CNT = 7;
`endif

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_e;

endpackage

// File: rtl/scan_mux8.sv
// Pure combinational 8:1 data selector.
module scan_mux8
  import scan_pkg::*;
(
  input  logic [DAT_W-1:0]  dat_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic              out_o
);

  assign out_o = dat_i[addr_i];

endmodule

// File: rtl/selector_scan_ctrl.sv
// Serialises an 8-bit word by stepping an 8:1 selector address, one bit per clock.
// Build option: SCAN_PARITY_EN adds a trailing even-parity bit per frame.
module selector_scan_ctrl
  import scan_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DAT_W-1:0]  in_dat,
  input  logic              msb_first,
  output logic [ADDR_W-1:0] sel_addr,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              frame_start,
  output logic              frame_last,
  output logic              busy
);

  state_e             state_q, state_d;
  logic [DAT_W-1:0]   dat_q, dat_d;
  logic               dir_q, dir_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rdy_q, rdy_d;
  logic               accept_c;
  logic               last_c;
  logic               step_en_c;
  logic               mux_bit_c;

  assign accept_c = in_valid & rdy_q;
  assign last_c   = (cnt_q == CNT_W'(LAST_CNT));

`ifdef SCAN_PARITY_EN
  // Address freezes on the final data bit while the parity bit goes out.
  assign step_en_c = (cnt_q < CNT_W'(DAT_W - 1));
`else
  assign step_en_c = 1'b1;
`endif

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    dat_d   = dat_q;
    dir_d   = dir_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    rdy_d   = 1'b0;

    case (state_q)
      ST_IDLE: state_d = ST_IDLE;
      ST_SCAN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (step_en_c) begin
          addr_d = dir_q ? addr_q - ADDR_W'(1) : addr_q + ADDR_W'(1);
        end
        if (last_c) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Accept is only possible in IDLE or on the last bit, so it overrides both.
    if (accept_c) begin
      state_d = ST_SCAN;
      dat_d   = in_dat;
      dir_d   = msb_first;
      addr_d  = msb_first ? ADDR_W'(DAT_W - 1) : ADDR_W'(0);
      cnt_d   = CNT_W'(0);
    end

    rdy_d = (state_d == ST_IDLE) | (cnt_d == CNT_W'(LAST_CNT));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      dat_q   <= '0;
      dir_q   <= 1'b0;
      addr_q  <= '0;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dat_q   <= dat_d;
      dir_q   <= dir_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_d;
    end
  end

  scan_mux8 u_mux (
    .dat_i  (dat_q),
    .addr_i (addr_q),
    .out_o  (mux_bit_c)
  );

`ifdef SCAN_PARITY_EN
  assign ser_out = last_c ? (^dat_q) : mux_bit_c;
`else
  assign ser_out = mux_bit_c;
`endif

  assign in_ready    = rdy_q;
  assign sel_addr    = addr_q;
  assign ser_valid   = (state_q == ST_SCAN);
  assign busy        = (state_q == ST_SCAN);
  assign frame_start = (state_q == ST_SCAN) & (cnt_q == CNT_W'(0));
  assign frame_last  = (state_q == ST_SCAN) & last_c;

endmodule
